// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: Set-2 scan byte parser with per-side modifier tracking and a show-ahead event FIFO
module ps2_key_event_decoder #(
    parameter int FIFO_AW = 3,
    parameter int REPORT_BREAKS = 0,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       ev_pop,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [3:0] ev_mods,
    output logic       caps_lock,
    output logic       overflow
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;
    localparam int DEPTH = 1 << FIFO_AW;

    logic [2:0] state, state_nxt;
    logic [2:0] skip_cnt, skip_nxt;
    logic       done;
    logic [7:0] c_code;
    logic       c_ext, c_brk;

    logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held;
    logic       lm_valid;
    logic [8:0] lm;

    logic key_lshift, key_rshift, key_lctrl, key_rctrl, key_lalt, key_ralt, key_caps;
    logic is_mod, fake_shift, other, repeat_hit, push;
    logic [3:0]  mods_now;
    logic [13:0] entry, head;

    logic [13:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             empty, full, do_pop, do_push;

    // Byte parser: decides when a byte completes a key sequence and what it means
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        done      = 1'b0;
        c_code    = rx_data;
        c_ext     = 1'b0;
        c_brk     = 1'b0;
        if (rx_done_tick) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == 8'hE0)
                        state_nxt = S_EXT;
                    else if (rx_data == 8'hF0)
                        state_nxt = S_BRK;
                    else if (rx_data == 8'hE1) begin
                        state_nxt = S_PAUSE;
                        skip_nxt  = 3'd7;
                    end else
                        done = 1'b1;
                end
                S_EXT: begin
                    if (rx_data == 8'hF0)
                        state_nxt = S_EXT_BRK;
                    else begin
                        done      = 1'b1;
                        c_ext     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    done      = 1'b1;
                    c_brk     = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    done      = 1'b1;
                    c_ext     = 1'b1;
                    c_brk     = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        done      = 1'b1;
                        c_ext     = 1'b1;
                        c_code    = 8'hE1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Parser state register; reset abandons any partial sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Classify the completed key and decide whether it becomes a queued event
    always_comb begin
        key_lshift = (c_code == 8'h12) && !c_ext;
        key_rshift = (c_code == 8'h59) && !c_ext;
        key_lctrl  = (c_code == 8'h14) && !c_ext;
        key_rctrl  = (c_code == 8'h14) && c_ext;
        key_lalt   = (c_code == 8'h11) && !c_ext;
        key_ralt   = (c_code == 8'h11) && c_ext;
        key_caps   = (c_code == 8'h58) && !c_ext;
        fake_shift = (c_code == 8'h12) && c_ext;
        is_mod     = key_lshift | key_rshift | key_lctrl | key_rctrl | key_lalt | key_ralt | key_caps;
        other      = done && !fake_shift && !is_mod;
        repeat_hit = (SUPPRESS_REPEAT != 0) && lm_valid && (lm == {c_ext, c_code});
        push       = other && (c_brk ? (REPORT_BREAKS != 0) : !repeat_hit);
        mods_now   = {caps_lock, lalt | ralt, lctrl | rctrl, lshift | rshift};
        entry      = {mods_now, c_brk, c_ext, c_code};
    end

    // Modifier held flags, caps-lock toggle and last accepted make code
    always_ff @(posedge clk) begin
        if (reset) begin
            {lshift, rshift, lctrl, rctrl, lalt, ralt} <= 6'd0;
            caps_held <= 1'b0;
            caps_lock <= 1'b0;
            lm_valid  <= 1'b0;
            lm        <= 9'd0;
        end else if (done && !fake_shift) begin
            if (key_lshift) lshift <= !c_brk;
            if (key_rshift) rshift <= !c_brk;
            if (key_lctrl)  lctrl  <= !c_brk;
            if (key_rctrl)  rctrl  <= !c_brk;
            if (key_lalt)   lalt   <= !c_brk;
            if (key_ralt)   ralt   <= !c_brk;
            if (key_caps) begin
                if (c_brk)
                    caps_held <= 1'b0;
                else if (!caps_held) begin
                    caps_lock <= ~caps_lock;
                    caps_held <= 1'b1;
                end
            end
            if (other) begin
                if (c_brk)
                    lm_valid <= 1'b0;
                else begin
                    lm_valid <= 1'b1;
                    lm       <= {c_ext, c_code};
                end
            end
        end
    end

    // FIFO status; a pop on an empty FIFO is ignored, a full FIFO accepts a push only alongside a pop
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
        do_pop  = ev_pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr[FIFO_AW-1:0]];
        ev_valid = !empty;
        {ev_mods, ev_break, ev_ext, ev_code} = ev_valid ? head : 14'd0;
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= entry;
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end
endmodule
